// File: rtl/sweep_result_store_if.sv
// rtl/sweep_result_store_if.sv - capture strobes and read bus of the sweep result store
interface sweep_result_store_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    // capture side: modulus and phase results with their point indices
    logic                  VALID_M;
    logic [DATA_WIDTH-1:0] MODULO;
    logic [ADDR_WIDTH-1:0] addr_m;
    logic                  VALID_P;
    logic [DATA_WIDTH-1:0] PHASE;
    logic [ADDR_WIDTH-1:0] addr_p;

    // system-bus read side; rd_addr MSB selects the phase store
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output VALID_M, MODULO, addr_m,
        output VALID_P, PHASE, addr_p,
        output rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  VALID_M, MODULO, addr_m,
        input  VALID_P, PHASE, addr_p,
        input  rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/sweep_result_store.sv
// rtl/sweep_result_store.sv - per-point modulus/phase capture store for one frequency sweep
module sweep_result_store #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk125,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] n_points,
    sweep_result_store_if.slave   bus,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count_m,
    output logic [ADDR_WIDTH:0]   count_p,
    output logic                  err_dup,
    output logic                  err_range
);
    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ARMED = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_start_q;
    logic [ADDR_WIDTH:0]     r_n_eff;
    logic [ADDR_WIDTH-1:0]   r_clr_idx;
    logic [ADDR_WIDTH:0]     r_count_m;
    logic [ADDR_WIDTH:0]     r_count_p;
    logic                    r_err_dup;
    logic                    r_err_range;
    logic [DEPTH-1:0]        r_wr_m;
    logic [DEPTH-1:0]        r_wr_p;
    logic [DATA_WIDTH-1:0]   r_mem_m [DEPTH];
    logic [DATA_WIDTH-1:0]   r_mem_p [DEPTH];
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;

    logic                    w_start_rise;
    logic                    w_enter_clear;
    logic                    w_clearing;
    logic                    w_clr_last;
    logic                    w_capture_ok;
    logic                    w_in_m;
    logic                    w_in_p;
    logic                    w_cap_m;
    logic                    w_cap_p;
    logic                    w_rng_m;
    logic                    w_rng_p;

    assign w_start_rise = start & ~r_start_q;
    assign w_clr_last   = (r_clr_idx == IDX_LAST);
    // clearing is suppressed on a reset edge so an interrupted CLEAR stops touching the stores
    assign w_clearing   = (r_state == S_CLEAR) && !reset;
    // an abort edge in ARMED wins over any strobe arriving in the same cycle
    assign w_capture_ok = (r_state == S_ARMED) && !w_start_rise && !reset;
    assign w_in_m       = ({1'b0, bus.addr_m} < r_n_eff);
    assign w_in_p       = ({1'b0, bus.addr_p} < r_n_eff);
    assign w_cap_m      = w_capture_ok & bus.VALID_M & w_in_m;
    assign w_cap_p      = w_capture_ok & bus.VALID_P & w_in_p;
    assign w_rng_m      = w_capture_ok & bus.VALID_M & ~w_in_m;
    assign w_rng_p      = w_capture_ok & bus.VALID_P & ~w_in_p;

    // state register and start edge history
    always_ff @(posedge clk125) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
        end
    end

    // next-state logic; completion is judged on the registered counts
    always_comb begin
        w_state_nxt   = r_state;
        w_enter_clear = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt   = S_CLEAR;
                    w_enter_clear = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_clr_last) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (w_start_rise) begin
                    w_state_nxt   = S_CLEAR;
                    w_enter_clear = 1'b1;
                end else if ((r_count_m == r_n_eff) && (r_count_p == r_n_eff)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_start_rise) begin
                    w_state_nxt   = S_CLEAR;
                    w_enter_clear = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // sweep bookkeeping: effective length, clear index, counts and sticky errors
    always_ff @(posedge clk125) begin
        if (reset) begin
            r_n_eff     <= DEPTH_W;
            r_clr_idx   <= '0;
            r_count_m   <= '0;
            r_count_p   <= '0;
            r_err_dup   <= 1'b0;
            r_err_range <= 1'b0;
        end else if (w_enter_clear) begin
            r_n_eff     <= (n_points == '0) ? DEPTH_W : {1'b0, n_points};
            r_clr_idx   <= '0;
            r_count_m   <= '0;
            r_count_p   <= '0;
            r_err_dup   <= 1'b0;
            r_err_range <= 1'b0;
        end else begin
            if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + IDX_ONE;
            if (w_cap_m) begin
                if (r_wr_m[bus.addr_m]) r_err_dup <= 1'b1;
                else                    r_count_m <= r_count_m + CNT_ONE;
            end
            if (w_cap_p) begin
                if (r_wr_p[bus.addr_p]) r_err_dup <= 1'b1;
                else                    r_count_p <= r_count_p + CNT_ONE;
            end
            if (w_rng_m || w_rng_p) r_err_range <= 1'b1;
        end
    end

    // per-index written bits; only meaningful once a CLEAR pass has swept them
    always_ff @(posedge clk125) begin
        if (w_clearing) begin
            r_wr_m[r_clr_idx] <= 1'b0;
            r_wr_p[r_clr_idx] <= 1'b0;
        end
        if (w_cap_m) r_wr_m[bus.addr_m] <= 1'b1;
        if (w_cap_p) r_wr_p[bus.addr_p] <= 1'b1;
    end

    // result stores: zero-fill during CLEAR, capture writes during ARMED
    always_ff @(posedge clk125) begin
        if (w_clearing) begin
            r_mem_m[r_clr_idx] <= '0;
            r_mem_p[r_clr_idx] <= '0;
        end
        if (w_cap_m) r_mem_m[bus.addr_m] <= bus.MODULO;
        if (w_cap_p) r_mem_p[bus.addr_p] <= bus.PHASE;
    end

    // one-cycle read port; a colliding write is seen on the following read
    always_ff @(posedge clk125) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= bus.rd_addr[ADDR_WIDTH] ? r_mem_p[bus.rd_addr[ADDR_WIDTH-1:0]]
                                                     : r_mem_m[bus.rd_addr[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign busy         = (r_state == S_CLEAR) || (r_state == S_ARMED);
    assign done         = (r_state == S_DONE);
    assign count_m      = r_count_m;
    assign count_p      = r_count_p;
    assign err_dup      = r_err_dup;
    assign err_range    = r_err_range;
endmodule

// File: tb/tb_sweep_result_store.sv
// tb/tb_sweep_result_store.sv - self-checking bench for sweep_result_store
module tb_sweep_result_store;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clk125 = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] n_points;
    logic          busy, done, err_dup, err_range;
    logic [AW:0]   count_m, count_p;

    sweep_result_store_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sweep_result_store #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk125   (clk125),
        .reset    (reset),
        .start    (start),
        .n_points (n_points),
        .bus      (bus.slave),
        .busy     (busy),
        .done     (done),
        .count_m  (count_m),
        .count_p  (count_p),
        .err_dup  (err_dup),
        .err_range(err_range)
    );

    always #4 clk125 = ~clk125;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_CLEAR, M_ARMED, M_DONE} mmode_t;
    mmode_t        m_mode = M_IDLE;
    bit            m_ok = 0;
    bit            m_known = 0;
    bit            m_sp = 0;
    int            m_neff = DEPTH;
    int            m_ci = 0;
    int            m_cm = 0, m_cp = 0;
    bit            m_edup = 0, m_erng = 0;
    bit            m_rdv = 0;
    bit            m_rd_known = 1;
    logic [DW-1:0] m_rdd = '0;
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] pp [DEPTH];
    bit            wm [DEPTH];
    bit            wp [DEPTH];

    function automatic void m_enter_clear();
        m_neff = (n_points == 0) ? DEPTH : int'(n_points);
        m_cm = 0; m_cp = 0; m_edup = 0; m_erng = 0; m_ci = 0;
        m_mode = M_CLEAR;
    endfunction

    always @(posedge clk125) begin
        bit edge_s, fin;
        int a;
        if (reset) begin
            m_mode = M_IDLE; m_cm = 0; m_cp = 0; m_edup = 0; m_erng = 0;
            m_rdv = 0; m_rdd = '0; m_rd_known = 1; m_sp = 0; m_known = 0; m_ok = 1;
        end else begin
            edge_s = start && !m_sp;
            m_sp = start;
            m_rdv = bus.rd_en;
            if (bus.rd_en) begin
                a = int'(bus.rd_addr[AW-1:0]);
                m_rdd = bus.rd_addr[AW] ? pp[a] : mm[a];
                m_rd_known = m_known;
            end
            case (m_mode)
                M_IDLE: if (edge_s) m_enter_clear();
                M_CLEAR: begin
                    mm[m_ci] = '0; pp[m_ci] = '0; wm[m_ci] = 0; wp[m_ci] = 0;
                    m_ci++;
                    if (m_ci == DEPTH) begin m_mode = M_ARMED; m_known = 1; end
                end
                M_ARMED: begin
                    if (edge_s) m_enter_clear();
                    else begin
                        fin = (m_cm == m_neff) && (m_cp == m_neff);
                        if (bus.VALID_M) begin
                            a = int'(bus.addr_m);
                            if (a < m_neff) begin
                                if (wm[a]) m_edup = 1; else begin wm[a] = 1; m_cm++; end
                                mm[a] = bus.MODULO;
                            end else m_erng = 1;
                        end
                        if (bus.VALID_P) begin
                            a = int'(bus.addr_p);
                            if (a < m_neff) begin
                                if (wp[a]) m_edup = 1; else begin wp[a] = 1; m_cp++; end
                                pp[a] = bus.PHASE;
                            end else m_erng = 1;
                        end
                        if (fin) m_mode = M_DONE;
                    end
                end
                M_DONE: if (edge_s) m_enter_clear();
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk125) begin
        if (m_ok) begin
            chk("busy",      64'(busy),      64'(m_mode == M_CLEAR || m_mode == M_ARMED));
            chk("done",      64'(done),      64'(m_mode == M_DONE));
            chk("count_m",   64'(count_m),   64'(m_cm));
            chk("count_p",   64'(count_p),   64'(m_cp));
            chk("err_dup",   64'(err_dup),   64'(m_edup));
            chk("err_range", 64'(err_range), 64'(m_erng));
            chk("rd_valid",  64'(bus.rd_valid), 64'(m_rdv));
            if (m_rd_known) chk("rd_data", 64'(bus.rd_data), 64'(m_rdd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk125);
        #1;
    endtask

    task automatic pulse_start_and_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (DEPTH) tick();
    endtask

    task automatic strobe(input bit vm, input int am, input logic [DW-1:0] dm,
                          input bit vp, input int ap, input logic [DW-1:0] dp);
        bus.VALID_M = vm; bus.addr_m = AW'(am); bus.MODULO = dm;
        bus.VALID_P = vp; bus.addr_p = AW'(ap); bus.PHASE = dp;
        tick();
        bus.VALID_M = 1'b0; bus.VALID_P = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int addr, input logic [DW-1:0] exp);
        bus.rd_en = 1'b1;
        bus.rd_addr = (AW+1)'(addr);
        tick();
        bus.rd_en = 1'b0;
        chk(name, 64'(bus.rd_data), 64'(exp));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n_points = '0;
        bus.VALID_M = 1'b0; bus.MODULO = '0; bus.addr_m = '0;
        bus.VALID_P = 1'b0; bus.PHASE = '0; bus.addr_p = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        repeat (3) tick();
        reset = 1'b0;

        chk("reset_busy",     64'(busy),         64'd0);
        chk("reset_done",     64'(done),         64'd0);
        chk("reset_count_m",  64'(count_m),      64'd0);
        chk("reset_err",      64'({err_dup, err_range}), 64'd0);
        chk("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("reset_rd_data",  64'(bus.rd_data),  64'd0);

        // full 4-point sweep
        n_points = 8'd4;
        pulse_start_and_clear();
        chk("armed_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) strobe(1, i, DW'(100 + i), 1, i, DW'(-i));
        chk("t1_counts", 64'({count_m, count_p}), {46'd0, 9'd4, 9'd4});
        chk("t1_done_not_yet", 64'(done), 64'd0);
        tick();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy_low", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) rd_chk("t1_mod", i, DW'(100 + i));
        rd_chk("t1_ph0", 'h100, 32'h0000_0000);
        rd_chk("t1_ph1", 'h101, 32'hFFFF_FFFF);
        rd_chk("t1_ph2", 'h102, 32'hFFFF_FFFE);
        rd_chk("t1_ph3", 'h103, 32'hFFFF_FFFD);
        strobe(1, 0, 32'd555, 0, 0, 0);
        rd_chk("t1_done_frozen", 'h000, 32'd100);

        // duplicate capture
        n_points = 8'd3;
        pulse_start_and_clear();
        strobe(1, 1, 32'd5, 0, 0, 0);
        strobe(1, 1, 32'd9, 0, 0, 0);
        chk("t2_err_dup", 64'(err_dup), 64'd1);
        chk("t2_count_m", 64'(count_m), 64'd1);
        rd_chk("t2_mod1", 'h001, 32'd9);

        // out-of-range index
        n_points = 8'd2;
        pulse_start_and_clear();
        chk("t3_dup_cleared", 64'(err_dup), 64'd0);
        strobe(0, 0, 0, 1, 7, 32'h1234);
        chk("t3_err_range", 64'(err_range), 64'd1);
        chk("t3_count_p", 64'(count_p), 64'd0);
        rd_chk("t3_ph7", 'h107, 32'd0);

        // simultaneous strobes with crossed indices
        n_points = 8'd2;
        pulse_start_and_clear();
        strobe(1, 0, 32'd11, 1, 1, 32'd21);
        strobe(1, 1, 32'd12, 1, 0, 32'd20);
        chk("t4_counts", 64'({count_m, count_p}), {46'd0, 9'd2, 9'd2});
        tick();
        chk("t4_done", 64'(done), 64'd1);
        rd_chk("t4_ph1", 'h101, 32'd21);

        // abort while armed
        n_points = 8'd4;
        pulse_start_and_clear();
        strobe(1, 0, 32'd77, 0, 0, 0);
        strobe(1, 1, 32'd78, 0, 0, 0);
        chk("t5_count_m", 64'(count_m), 64'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_counts_zero", 64'({count_m, count_p}), 64'd0);
        repeat (DEPTH) tick();
        bus.rd_en = 1'b1;
        for (int a = 0; a < 2 * DEPTH; a++) begin
            bus.rd_addr = (AW+1)'(a);
            tick();
            chk("t5_zero", 64'(bus.rd_data), 64'd0);
        end
        bus.rd_en = 1'b0;

        // reset during CLEAR with full-depth sweep
        n_points = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", 64'(busy), 64'd0);
        strobe(1, 0, 32'd3, 1, 0, 32'd3);
        chk("t6_ignored", 64'({count_m, count_p}), 64'd0);
        pulse_start_and_clear();
        strobe(1, 200, 32'd7, 0, 0, 0);
        chk("t6_count_m", 64'(count_m), 64'd1);
        chk("t6_no_range", 64'(err_range), 64'd0);
        rd_chk("t6_mod200", 200, 32'd7);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
